// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side bus of the two-port ALU arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [5:0]  req0_alucode;
    logic [31:0] req0_opr1;
    logic [31:0] req0_opr2;
    logic [3:0]  req0_tag;

    logic        req1_valid;
    logic        req1_ready;
    logic [5:0]  req1_alucode;
    logic [31:0] req1_opr1;
    logic [31:0] req1_opr2;
    logic [3:0]  req1_tag;

    logic [5:0]  alu_alucode;
    logic [31:0] alu_opr1;
    logic [31:0] alu_opr2;
    logic [31:0] alu_result;
    logic        alu_br_taken;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_result;
    logic        rsp0_br_taken;
    logic [3:0]  rsp0_tag;

    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_result;
    logic        rsp1_br_taken;
    logic [3:0]  rsp1_tag;

    modport slave (
        input  req0_valid, req0_alucode, req0_opr1,
        input  req0_opr2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_alucode, req1_opr1,
        input  req1_opr2, req1_tag,
        output req1_ready,
        output alu_alucode, alu_opr1, alu_opr2,
        input  alu_result, alu_br_taken,
        output rsp0_valid, rsp0_result, rsp0_br_taken,
        output rsp0_tag,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_br_taken,
        output rsp1_tag,
        input  rsp1_ready
    );

    modport master (
        output req0_valid, req0_alucode, req0_opr1,
        output req0_opr2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_alucode, req1_opr1,
        output req1_opr2, req1_tag,
        input  req1_ready,
        input  alu_alucode, alu_opr1, alu_opr2,
        output alu_result, alu_br_taken,
        input  rsp0_valid, rsp0_result, rsp0_br_taken,
        input  rsp0_tag,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_br_taken,
        input  rsp1_tag,
        output rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the execute ALU between two requesters,
// with a one-entry registered response slot per port.
`ifndef ALU_ADD
`define ALU_ADD 6'd0
`endif

module alu_arbiter #(
    parameter logic [5:0] IDLE_CODE = `ALU_ADD,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic elig0, elig1;
    logic grant0, grant1;
    logic last_grant;

    // Nothing is accepted while reset is asserted.
    assign elig0 = rst_n && bus.req0_valid &&
                   (!bus.rsp0_valid || bus.rsp0_ready);
    assign elig1 = rst_n && bus.req1_valid &&
                   (!bus.rsp1_valid || bus.rsp1_ready);

    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        bus.alu_alucode = IDLE_CODE;
        bus.alu_opr1    = '0;
        bus.alu_opr2    = '0;
        unique case (1'b1)
            grant0: begin
                bus.alu_alucode = bus.req0_alucode;
                bus.alu_opr1    = bus.req0_opr1;
                bus.alu_opr2    = bus.req0_opr2;
            end
            grant1: begin
                bus.alu_alucode = bus.req1_alucode;
                bus.alu_opr1    = bus.req1_opr1;
                bus.alu_opr2    = bus.req1_opr2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp0_valid    <= 1'b0;
            bus.rsp0_result   <= '0;
            bus.rsp0_br_taken <= 1'b0;
            bus.rsp0_tag      <= '0;
            bus.rsp1_valid    <= 1'b0;
            bus.rsp1_result   <= '0;
            bus.rsp1_br_taken <= 1'b0;
            bus.rsp1_tag      <= '0;
            last_grant        <= 1'b1;
            conflict_cnt      <= '0;
        end else begin
            if (grant0) begin
                bus.rsp0_valid    <= 1'b1;
                bus.rsp0_result   <= bus.alu_result;
                bus.rsp0_br_taken <= bus.alu_br_taken;
                bus.rsp0_tag      <= bus.req0_tag;
            end else if (bus.rsp0_ready) begin
                bus.rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                bus.rsp1_valid    <= 1'b1;
                bus.rsp1_result   <= bus.alu_result;
                bus.rsp1_br_taken <= bus.alu_br_taken;
                bus.rsp1_tag      <= bus.req1_tag;
            end else if (bus.rsp1_ready) begin
                bus.rsp1_valid <= 1'b0;
            end

            if (grant0 || grant1)
                last_grant <= grant1;

            if (elig0 && elig1 && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a tiny ALU model answers on the bus.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_BEQ = 6'd16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt;
    int         errors = 0;
    int         checks = 0;

    alu_arbiter_if bus ();

    alu_arbiter #(.IDLE_CODE(OP_ADD), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .conflict_cnt (cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.alu_result   = 32'd0;
        bus.alu_br_taken = 1'b0;
        case (bus.alu_alucode)
            OP_ADD: bus.alu_result = bus.alu_opr1 + bus.alu_opr2;
            OP_SUB: bus.alu_result = bus.alu_opr1 - bus.alu_opr2;
            OP_BEQ: bus.alu_br_taken = (bus.alu_opr1 == bus.alu_opr2);
            default: bus.alu_result = 32'hdead_beef;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
        bus.req0_valid   = v;
        bus.req0_alucode = op;
        bus.req0_opr1    = a;
        bus.req0_opr2    = b;
        bus.req0_tag     = t;
    endtask

    task automatic set1(input logic v, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
        bus.req1_valid   = v;
        bus.req1_alucode = op;
        bus.req1_opr1    = a;
        bus.req1_opr2    = b;
        bus.req1_tag     = t;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd0);
        set1(1'b1, OP_ADD, 32'd2, 32'd2, 4'd0);

        // reset with both requests valid
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst_cnt", {28'd0, cnt}, 32'd0);
        chk("rst_alucode", {26'd0, bus.alu_alucode}, 32'd0);

        // single request on port 0
        rst_n = 1'b1;
        set1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        set0(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
        #1;
        chk("p0_ready", {31'd0, bus.req0_ready}, 32'd1);
        chk("p0_alu_opr1", bus.alu_opr1, 32'd5);
        chk("p0_alu_opr2", bus.alu_opr2, 32'd7);
        @(posedge clk); #1;
        chk("p0_rsp_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("p0_rsp_result", bus.rsp0_result, 32'd12);
        chk("p0_rsp_br", {31'd0, bus.rsp0_br_taken}, 32'd0);
        chk("p0_rsp_tag", {28'd0, bus.rsp0_tag}, 32'd3);

        // reset again so port 0 wins the first conflict
        @(negedge clk);
        rst_n = 1'b0;
        set0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set0(1'b1, OP_SUB, 32'd10, 32'd3, 4'd1);
        set1(1'b1, OP_BEQ, 32'd4, 32'd4, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", {31'd0, bus.req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, bus.req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("rr_rsp0_result", bus.rsp0_result, 32'd7);
        chk("rr_rsp0_tag", {28'd0, bus.rsp0_tag}, 32'd1);
        chk("rr_rsp1_br", {31'd0, bus.rsp1_br_taken}, 32'd1);
        chk("rr_rsp1_result", bus.rsp1_result, 32'd0);
        chk("rr_rsp1_tag", {28'd0, bus.rsp1_tag}, 32'd2);
        chk("rr_cnt", {28'd0, cnt}, 32'd4);

        // port 1 response stalled; port 0 keeps issuing
        bus.rsp1_ready = 1'b0;
        set1(1'b1, OP_ADD, 32'd8, 32'd9, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
            chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd1);
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, bus.rsp1_valid}, 32'd1);
            chk("bp_hold_result", bus.rsp1_result, 32'd0);
            chk("bp_hold_br", {31'd0, bus.rsp1_br_taken}, 32'd1);
            chk("bp_hold_tag", {28'd0, bus.rsp1_tag}, 32'd2);
        end
        chk("bp_cnt", {28'd0, cnt}, 32'd4);
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_resume_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("bp_resume_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("bp_pre_accept", bus.rsp1_result, 32'd0);
        @(negedge clk);
        chk("bp_new_result", bus.rsp1_result, 32'd17);
        chk("bp_new_tag", {28'd0, bus.rsp1_tag}, 32'd5);
        chk("bp_new_br", {31'd0, bus.rsp1_br_taken}, 32'd0);

        // back-to-back on port 0
        set1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            set0(1'b1, OP_ADD, i, i, 4'(i));
            @(negedge clk);
            chk("b2b_valid", {31'd0, bus.rsp0_valid}, 32'd1);
            chk("b2b_result", bus.rsp0_result, 32'(2 * i));
            chk("b2b_tag", {28'd0, bus.rsp0_tag}, 32'(i));
        end
        set0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        #1;
        chk("idle_alucode", {26'd0, bus.alu_alucode}, 32'd0);
        chk("idle_opr1", bus.alu_opr1, 32'd0);
        @(negedge clk);
        chk("drain_valid", {31'd0, bus.rsp0_valid}, 32'd0);

        // counter saturation, then reset with a held response
        set0(1'b1, OP_ADD, 32'd1, 32'd2, 4'd9);
        set1(1'b1, OP_ADD, 32'd3, 32'd4, 4'd8);
        repeat (20) @(negedge clk);
        chk("sat_cnt", {28'd0, cnt}, 32'd15);
        chk("sat_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst2_rsp0_result", bus.rsp0_result, 32'd0);
        chk("rst2_rsp0_tag", {28'd0, bus.rsp0_tag}, 32'd0);
        chk("rst2_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst2_rsp1_result", bus.rsp1_result, 32'd0);
        chk("rst2_cnt", {28'd0, cnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst2_first_win0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rst2_first_lose1", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
